// File: rtl/conv_3x3_seq.sv
// conv_3x3_seq: accepts one 3x3 pixel window per handshake, streams the nine pixel/weight
// pairs into the serial MAC, waits out its latency and returns the result. Build macro: CONV3X3_SEQ_PERF_EN.
module conv_3x3_seq #(
    parameter int ANS_LAT = 1,
    parameter int TAPS    = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wt_load,
    input  logic [7:0]  wt_in,
    output logic        wt_ok,
    input  logic        win_valid,
    output logic        win_ready,
    input  logic [71:0] win_data,
    output logic        mac_clr,
    output logic [7:0]  mac_data,
    output logic [7:0]  mac_weight,
    input  logic [7:0]  mac_ans,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data
`ifdef CONV3X3_SEQ_PERF_EN
    ,
    output logic [15:0] perf_win_cnt,
    output logic [15:0] perf_stall_cnt
`endif
);

    // Both handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // the producer holds valid and its payload unchanged until that edge.

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_HOLD} state_t;

    localparam logic [3:0] LAST_TAP = 4'(TAPS - 1);
    localparam logic [3:0] LAT_INIT = 4'(ANS_LAT);

    state_t      state_q;
    logic [7:0]  wt_q [TAPS];
    logic [3:0]  wr_ptr_q;
    logic        wt_ok_q;
    logic [3:0]  tap_q;
    logic [3:0]  lat_q;
    logic [71:0] win_q;
    logic        mac_clr_q;
    logic [7:0]  mac_data_q;
    logic [7:0]  mac_weight_q;
    logic        out_valid_q;
    logic [7:0]  out_data_q;

    logic [3:0]  tap_d;
    logic        wt_write;
    logic        win_fire;
    logic        out_fire;

    assign tap_d     = tap_q + 4'd1;
    assign wt_write  = (state_q == S_IDLE) && wt_load;
    assign win_ready = (state_q == S_IDLE) && wt_ok_q && !wt_load;
    assign win_fire  = win_valid && win_ready;
    assign out_fire  = out_valid_q && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            for (int i = 0; i < TAPS; i++) wt_q[i] <= '0;
            wr_ptr_q     <= '0;
            wt_ok_q      <= 1'b0;
            tap_q        <= '0;
            lat_q        <= '0;
            win_q        <= '0;
            mac_clr_q    <= 1'b0;
            mac_data_q   <= '0;
            mac_weight_q <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
        end else begin
            if (wt_write) begin
                wt_q[wr_ptr_q] <= wt_in;
                if (wr_ptr_q == LAST_TAP) begin
                    wr_ptr_q <= '0;
                    wt_ok_q  <= 1'b1;
                end else begin
                    wr_ptr_q <= wr_ptr_q + 4'd1;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (win_fire) begin
                        // Tap 0 goes out on the very next cycle; the rest is kept as a shift register.
                        state_q      <= S_STREAM;
                        tap_q        <= '0;
                        win_q        <= win_data >> 8;
                        mac_clr_q    <= 1'b1;
                        mac_data_q   <= win_data[7:0];
                        mac_weight_q <= wt_q[0];
                    end
                end
                S_STREAM: begin
                    mac_clr_q <= 1'b0;
                    if (tap_q == LAST_TAP) begin
                        state_q      <= S_DRAIN;
                        lat_q        <= LAT_INIT;
                        mac_data_q   <= '0;
                        mac_weight_q <= '0;
                    end else begin
                        tap_q        <= tap_d;
                        mac_data_q   <= win_q[7:0];
                        mac_weight_q <= wt_q[tap_d];
                        win_q        <= win_q >> 8;
                    end
                end
                S_DRAIN: begin
                    if (lat_q <= 4'd1) begin
                        out_data_q  <= mac_ans;
                        out_valid_q <= 1'b1;
                        state_q     <= S_HOLD;
                    end else begin
                        lat_q <= lat_q - 4'd1;
                    end
                end
                S_HOLD: begin
                    if (out_fire) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign wt_ok      = wt_ok_q;
    assign mac_clr    = mac_clr_q;
    assign mac_data   = mac_data_q;
    assign mac_weight = mac_weight_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;

`ifdef CONV3X3_SEQ_PERF_EN
    logic [15:0] perf_win_q;
    logic [15:0] perf_stall_q;

    // Window count wraps; stall count saturates so long stalls stay visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_win_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            if (out_fire) perf_win_q <= perf_win_q + 16'd1;
            if ((state_q == S_HOLD) && !out_ready && (perf_stall_q != 16'hFFFF))
                perf_stall_q <= perf_stall_q + 16'd1;
        end
    end

    assign perf_win_cnt   = perf_win_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule
